// File: rtl/pit_controller.sv
// Programmable interval timer controller.
// Register-mapped down-counter with optional auto-reload. Expiry sets a
// sticky status flag, and that flag is gated by the interrupt enable to
// produce a level interrupt.
module pit_controller #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLOCK,
  input  logic             RST_N,
  input  logic             WR_EN,
  input  logic             RD_EN,
  input  logic [1:0]       ADDR,
  input  logic [WIDTH-1:0] WDATA,
  output logic [WIDTH-1:0] RDATA,
  output logic             INTERRUPT,
  output logic [WIDTH-1:0] COUNT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] A_CONTROL = 2'd0;
  localparam logic [1:0] A_DELAY   = 2'd1;
  localparam logic [1:0] A_COUNT   = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  state_t           r_state;
  logic [2:0]       r_ctrl;     // [0] en, [1] ie, [2] reload
  logic [WIDTH-1:0] r_delay;
  logic [WIDTH-1:0] r_count;
  logic             r_expired;
  logic [WIDTH-1:0] r_rdata;

  logic             w_wr_ctrl;
  logic             w_wr_delay;
  logic             w_wr_status;
  logic             w_expire;
  logic [WIDTH-1:0] w_rd_mux;

  assign w_wr_ctrl   = WR_EN && (ADDR == A_CONTROL);
  assign w_wr_delay  = WR_EN && (ADDR == A_DELAY);
  assign w_wr_status = WR_EN && (ADDR == A_STATUS);

  // A CONTROL write on the same edge overrides the terminal count, so it
  // also suppresses the expiry that edge would otherwise have produced.
  assign w_expire = (r_state == S_RUN) && (r_count == WIDTH'(1)) && !w_wr_ctrl;

  // Sequencing state, control bits and the down-counter.
  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_ctrl  <= '0;
      r_count <= '0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= WDATA[2:0];
      if (WDATA[0] && (r_delay != '0)) begin
        r_state <= S_RUN;
        r_count <= r_delay;
      end else begin
        r_state <= S_IDLE;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_expire) begin
            if (r_ctrl[2]) begin
              r_count <= r_delay;
            end else begin
              r_count <= '0;
              r_state <= S_DONE;
            end
          end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
          end
        end
        S_IDLE:  r_state <= S_IDLE;
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reload value; a change mid-run only takes effect at the next load.
  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      r_delay <= '0;
    end else if (w_wr_delay) begin
      r_delay <= WDATA;
    end
  end

  // Sticky expiry flag with write-1-to-clear; a new expiry beats the clear.
  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      r_expired <= 1'b0;
    end else if (w_expire) begin
      r_expired <= 1'b1;
    end else if (w_wr_status && WDATA[0]) begin
      r_expired <= 1'b0;
    end
  end

  // Read-data select from the current register contents.
  always_comb begin
    w_rd_mux = '0;
    case (ADDR)
      A_CONTROL: w_rd_mux = {{(WIDTH-3){1'b0}}, r_ctrl};
      A_DELAY:   w_rd_mux = r_delay;
      A_COUNT:   w_rd_mux = r_count;
      A_STATUS:  w_rd_mux = {{(WIDTH-1){1'b0}}, r_expired};
      default:   w_rd_mux = '0;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      r_rdata <= '0;
    end else if (RD_EN) begin
      r_rdata <= w_rd_mux;
    end
  end

  assign RDATA     = r_rdata;
  assign COUNT     = r_count;
  assign INTERRUPT = r_expired & r_ctrl[1];

endmodule

// File: tb/tb_pit_controller.sv
// Scoreboard bench for pit_controller.
// The reference model tracks the absolute cycle of the next expiry rather
// than a counter, and derives COUNT from it.
module tb_pit_controller;

  localparam int unsigned WIDTH = 32;

  logic             CLOCK = 1'b1;
  logic             RST_N = 1'b1;
  logic             WR_EN = 1'b0;
  logic             RD_EN = 1'b0;
  logic [1:0]       ADDR  = 2'd0;
  logic [WIDTH-1:0] WDATA = '0;
  logic [WIDTH-1:0] RDATA;
  logic             INTERRUPT;
  logic [WIDTH-1:0] COUNT;

  pit_controller #(.WIDTH(WIDTH)) dut (
    .CLOCK     (CLOCK),
    .RST_N     (RST_N),
    .WR_EN     (WR_EN),
    .RD_EN     (RD_EN),
    .ADDR      (ADDR),
    .WDATA     (WDATA),
    .RDATA     (RDATA),
    .INTERRUPT (INTERRUPT),
    .COUNT     (COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [31:0] cnt;
    logic        irq;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned m_cyc   = 0;
  bit          m_run   = 1'b0;
  int unsigned m_next  = 0;
  logic [31:0] m_frozen = '0;
  logic [31:0] m_delay  = '0;
  logic [31:0] m_rdata  = '0;
  logic [2:0]  m_ctrl   = '0;
  bit          m_exp    = 1'b0;

  function automatic logic [31:0] m_count();
    return m_run ? 32'(m_next - m_cyc) : m_frozen;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit we, input bit re, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] pre;
    int unsigned n;
    bit          set;
    pre = m_count();
    set = 1'b0;
    if (re) begin
      case (a)
        2'd0: m_rdata = {29'b0, m_ctrl};
        2'd1: m_rdata = m_delay;
        2'd2: m_rdata = pre;
        default: m_rdata = {31'b0, m_exp};
      endcase
    end
    n = m_cyc + 1;
    if (we && a == 2'd0) begin
      m_ctrl = d[2:0];
      if (d[0] && m_delay != 0) begin
        m_run  = 1'b1;
        m_next = n + m_delay;
      end else begin
        m_run    = 1'b0;
        m_frozen = pre;
      end
    end else if (m_run && n == m_next) begin
      set = 1'b1;
      if (m_ctrl[2]) begin
        m_next = n + m_delay;
      end else begin
        m_run    = 1'b0;
        m_frozen = '0;
      end
    end
    if (we && a == 2'd1) m_delay = d;
    if (set) m_exp = 1'b1;
    else if (we && a == 2'd3 && d[0]) m_exp = 1'b0;
    m_cyc = n;
    q.push_back('{m_count(), m_exp & m_ctrl[1], m_rdata});
  endtask

  task automatic step(input bit we, input bit re, input logic [1:0] a, input logic [31:0] d);
    @(negedge CLOCK);
    RST_N = 1'b1;
    WR_EN = we;
    RD_EN = re;
    ADDR  = a;
    WDATA = d;
    model_edge(we, re, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 2'd2, 32'd0);
  endtask

  // Asynchronous reset asserted between edges, checked before the next edge.
  task automatic do_reset();
    @(negedge CLOCK);
    RST_N = 1'b0;
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    #1;
    chk("async_rst_count", COUNT, 32'd0);
    chk("async_rst_irq", {31'b0, INTERRUPT}, 32'd0);
    chk("async_rst_rdata", RDATA, 32'd0);
    m_run = 1'b0; m_frozen = '0; m_delay = '0; m_rdata = '0;
    m_ctrl = '0;  m_exp = 1'b0;
    m_cyc = m_cyc + 1;
    q.push_back('{32'd0, 1'b0, 32'd0});
  endtask

  // Monitor: one expected entry per clock edge.
  initial begin
    exp_t e;
    #7;
    forever begin
      @(posedge CLOCK);
      #1;
      if (q.size() == 0) begin
        chk("queue_underflow", 32'd0, 32'd1);
      end else begin
        e = q.pop_front();
        chk("count", COUNT, e.cnt);
        chk("interrupt", {31'b0, INTERRUPT}, {31'b0, e.irq});
        chk("rdata", RDATA, e.rd);
      end
    end
  end

  initial begin
    int r;
    do_reset();

    // One-shot: DELAY=5, en+ie
    step(1'b1, 1'b0, 2'd1, 32'd5);
    step(1'b1, 1'b0, 2'd0, 32'd3);
    idle(7);
    step(1'b0, 1'b1, 2'd3, 32'd0);
    step(1'b0, 1'b1, 2'd0, 32'd0);

    // Auto-reload DELAY=3 with W1C on each expiry
    step(1'b1, 1'b0, 2'd1, 32'd3);
    step(1'b1, 1'b0, 2'd0, 32'd7);
    for (int i = 0; i < 12; i++) begin
      if (m_exp) step(1'b1, 1'b1, 2'd3, 32'd1);
      else       step(1'b0, 1'b1, 2'd3, 32'd0);
    end

    // DELAY change mid-run, then disable while counting
    step(1'b1, 1'b0, 2'd1, 32'd10);
    step(1'b1, 1'b0, 2'd0, 32'd7);
    for (int i = 0; i < 20 && m_count() != 4; i++) idle(1);
    step(1'b1, 1'b0, 2'd1, 32'd2);
    idle(7);
    for (int i = 0; i < 5 && m_count() != 2; i++) idle(1);
    step(1'b1, 1'b0, 2'd0, 32'd0);
    idle(4);

    // DELAY=0 never expires
    do_reset();
    step(1'b1, 1'b0, 2'd1, 32'd0);
    step(1'b1, 1'b0, 2'd0, 32'd3);
    idle(100);

    // DELAY=1 reload, W1C every cycle: set wins
    step(1'b1, 1'b0, 2'd1, 32'd1);
    step(1'b1, 1'b0, 2'd0, 32'd7);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 2'd3, 32'd1);
    step(1'b1, 1'b0, 2'd0, 32'd2);
    idle(3);

    // Mid-count asynchronous reset with DELAY=8
    step(1'b1, 1'b0, 2'd1, 32'd8);
    step(1'b1, 1'b0, 2'd0, 32'd3);
    for (int i = 0; i < 12 && m_count() != 4; i++) idle(1);
    do_reset();
    step(1'b0, 1'b1, 2'd2, 32'd0);
    step(1'b0, 1'b0, 2'd0, 32'd0);

    // Randomized register traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        6:  step(1'b1, $urandom_range(0, 1) == 1, 2'd0, $urandom);
        7:  step(1'b1, $urandom_range(0, 1) == 1, 2'd1, 32'($urandom_range(0, 6)));
        8:  step(1'b1, $urandom_range(0, 1) == 1, 2'd3, $urandom);
        9:  step(1'b1, $urandom_range(0, 1) == 1, 2'd2, $urandom);
        10: step(1'b1, 1'b0, 2'd0, {$urandom_range(0, 7) << 1} | 32'd1);
        default: step(1'b0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom);
      endcase
    end

    step(1'b0, 1'b0, 2'd0, 32'd0);
    @(posedge CLOCK);
    #2;
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
